mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/params_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 75 +++++++
 rtl/rr_arbiter2.sv | 52 +++++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared definitions for the memory arbiter slice.
//
// Contents:
//   PADDR_WIDTH       default physical address width
//   CACHE_LINE_BYTES  line size in bytes; memory data width is 8x this
//   access_size_t     access size carried with every memory request
//   FULL_LINE_SIZE    enumerator used for every instruction-side request
//   arb_state_t       arbiter FSM state encoding
package params_pkg;

    localparam int PADDR_WIDTH      = 32;
    localparam int CACHE_LINE_BYTES = 16;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_LINE  = 3'd4
    } access_size_t;

    // Instruction fetches always move a whole cache line.
    localparam access_size_t FULL_LINE_SIZE = SIZE_LINE;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache-side requesters, the memory port and
// the arbiter.
//
// Handshake semantics: a requester raises its request (ic_req_valid_i,
// dc_rd_req_i or dc_wr_req_i) and holds it, with stable fields, until the
// matching one-cycle response pulse (ic_rsp_valid_o, dc_rsp_valid_o,
// dc_wr_done_o). Towards memory, rd_req_valid_o / wr_req_valid_o are
// one-cycle pulses that memory must accept unconditionally; memory later
// answers with exactly one mem_data_valid_i or write_done_i pulse.
//
// Modports:
//   slave   the arbiter's view
//   master  the environment's view (caches + memory)
interface mem_arbiter_if #(
    parameter int PADDR_WIDTH = params_pkg::PADDR_WIDTH,
    parameter int LINE_WIDTH  = params_pkg::CACHE_LINE_BYTES * 8
);
    import params_pkg::*;

    // Instruction side
    logic                   ic_req_valid_i;
    logic [PADDR_WIDTH-1:0] ic_req_addr_i;
    logic                   ic_rsp_valid_o;
    logic [LINE_WIDTH-1:0]  ic_rsp_data_o;

    // Data side
    logic                   dc_rd_req_i;
    logic                   dc_wr_req_i;
    logic [PADDR_WIDTH-1:0] dc_req_addr_i;
    logic [LINE_WIDTH-1:0]  dc_wr_data_i;
    access_size_t           dc_access_size_i;
    logic                   dc_rsp_valid_o;
    logic [LINE_WIDTH-1:0]  dc_rsp_data_o;
    logic                   dc_wr_done_o;

    // Memory side
    logic                   rd_req_valid_o;
    logic                   wr_req_valid_o;
    logic                   req_is_instr_o;
    logic [PADDR_WIDTH-1:0] req_address_o;
    logic [LINE_WIDTH-1:0]  wr_data_o;
    access_size_t           req_access_size_o;
    logic                   mem_data_valid_i;
    logic                   mem_data_is_instr_i;
    logic                   write_done_i;
    logic [LINE_WIDTH-1:0]  mem_data_i;

    // Status / debug
    logic                   err_o;
    logic [31:0]            busy_cycles_o;
    arb_state_t             dbg_state;

    modport slave (
        input  ic_req_valid_i, ic_req_addr_i,
        output ic_rsp_valid_o, ic_rsp_data_o,
        input  dc_rd_req_i, dc_wr_req_i, dc_req_addr_i, dc_wr_data_i, dc_access_size_i,
        output dc_rsp_valid_o, dc_rsp_data_o, dc_wr_done_o,
        output rd_req_valid_o, wr_req_valid_o, req_is_instr_o, req_address_o,
        output wr_data_o, req_access_size_o,
        input  mem_data_valid_i, mem_data_is_instr_i, write_done_i, mem_data_i,
        output err_o, busy_cycles_o, dbg_state
    );

    modport master (
        output ic_req_valid_i, ic_req_addr_i,
        input  ic_rsp_valid_o, ic_rsp_data_o,
        output dc_rd_req_i, dc_wr_req_i, dc_req_addr_i, dc_wr_data_i, dc_access_size_i,
        input  dc_rsp_valid_o, dc_rsp_data_o, dc_wr_done_o,
        input  rd_req_valid_o, wr_req_valid_o, req_is_instr_o, req_address_o,
        input  wr_data_o, req_access_size_o,
        output mem_data_valid_i, mem_data_is_instr_i, write_done_i, mem_data_i,
        input  err_o, busy_cycles_o, dbg_state
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the instruction and data sides.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_ic_i       instruction side is requesting
//   req_dc_i       data side is requesting
//   advance_i      the current grant is being taken this cycle
//   gnt_ic_o       grant to the instruction side (combinational)
//   gnt_dc_o       grant to the data side (combinational)
module rr_arbiter2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_ic_i,
    input  logic req_dc_i,
    input  logic advance_i,
    output logic gnt_ic_o,
    output logic gnt_dc_o
);

    // 1 = instruction side won the last contested grant. Resetting to the
    // instruction side makes the data side win the first contest.
    logic last_ic_q;
    logic contested;

    assign contested = req_ic_i && req_dc_i;

    always_comb begin
        gnt_ic_o = 1'b0;
        gnt_dc_o = 1'b0;
        if (contested) begin
            if (last_ic_q) begin
                gnt_dc_o = 1'b1;
            end else begin
                gnt_ic_o = 1'b1;
            end
        end else begin
            gnt_ic_o = req_ic_i;
            gnt_dc_o = req_dc_i;
        end
    end

    // Only contested grants move the pointer: an uncontested grant is not a
    // fairness decision, so it must not cost that side its next turn.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_ic_q <= 1'b1;
        end else if (advance_i && contested) begin
            last_ic_q <= gnt_ic_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: serialises instruction-line reads and data reads/writes
// onto a single memory port with one transaction outstanding at a time.
//
// Ports:
//   clk_i   sole clock, rising edge
//   rst_i   synchronous active-high reset; abandons any transaction
//   bus     mem_arbiter_if.slave: requester, memory, status and debug state
//
// Flow: IDLE grants and latches one request -> ISSUE pulses the memory
// request -> WAIT holds until the matching memory response -> RESP pulses
// the owner's response -> IDLE.
module mem_arbiter #(
    parameter int PADDR_WIDTH = params_pkg::PADDR_WIDTH,
    parameter int LINE_WIDTH  = params_pkg::CACHE_LINE_BYTES * 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);
    import params_pkg::*;

    arb_state_t             state_q;
    arb_state_t             state_d;

    logic                   gnt_ic;
    logic                   gnt_dc;
    logic                   grant;

    // Latched transaction
    logic                   owner_ic_q;
    logic                   is_write_q;
    logic [PADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0]  wr_data_q;
    access_size_t           size_q;

    logic [LINE_WIDTH-1:0]  ic_rsp_data_q;
    logic [LINE_WIDTH-1:0]  dc_rsp_data_q;
    logic                   err_q;
    logic [31:0]            busy_q;

    logic                   in_idle;
    logic                   in_wait;
    logic                   read_ok;
    logic                   write_ok;
    logic                   err_set;

    assign in_idle  = (state_q == ARB_IDLE);
    assign in_wait  = (state_q == ARB_WAIT);
    assign grant    = gnt_ic || gnt_dc;
    assign read_ok  = in_wait && !is_write_q && bus.mem_data_valid_i;
    assign write_ok = in_wait &&  is_write_q && bus.write_done_i;

    rr_arbiter2 u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_ic_i  (bus.ic_req_valid_i),
        .req_dc_i  (bus.dc_rd_req_i || bus.dc_wr_req_i),
        .advance_i (in_idle),
        .gnt_ic_o  (gnt_ic),
        .gnt_dc_o  (gnt_dc)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        bus.rd_req_valid_o = 1'b0;
        bus.wr_req_valid_o = 1'b0;
        bus.ic_rsp_valid_o = 1'b0;
        bus.dc_rsp_valid_o = 1'b0;
        bus.dc_wr_done_o   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.rd_req_valid_o = !is_write_q;
                bus.wr_req_valid_o =  is_write_q;
                state_d            = ARB_WAIT;
            end
            ARB_WAIT: begin
                // No timeout: memory latency is unbounded.
                if (read_ok || write_ok) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                bus.ic_rsp_valid_o = owner_ic_q;
                bus.dc_rsp_valid_o = !owner_ic_q && !is_write_q;
                bus.dc_wr_done_o   = !owner_ic_q &&  is_write_q;
                state_d            = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Protocol error detection (sticky in err_q)
    // ------------------------------------------------------------------
    always_comb begin
        err_set = 1'b0;
        // Simultaneous read and write from the data side: served as a write.
        if (in_idle && gnt_dc && bus.dc_rd_req_i && bus.dc_wr_req_i) begin
            err_set = 1'b1;
        end
        // Responses outside WAIT or of the wrong kind are dropped.
        if (bus.mem_data_valid_i && !read_ok) begin
            err_set = 1'b1;
        end
        if (bus.write_done_i && !write_ok) begin
            err_set = 1'b1;
        end
        // Wrong-side tag on read data: still delivered to the owner.
        if (read_ok && (bus.mem_data_is_instr_i != owner_ic_q)) begin
            err_set = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: grant latch, response data, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_ic_q    <= 1'b0;
            is_write_q    <= 1'b0;
            addr_q        <= '0;
            wr_data_q     <= '0;
            size_q        <= SIZE_BYTE;
            ic_rsp_data_q <= '0;
            dc_rsp_data_q <= '0;
            err_q         <= 1'b0;
            busy_q        <= '0;
        end else begin
            // Fields are captured once here; later changes on the request
            // inputs have no effect until the next IDLE.
            if (in_idle && grant) begin
                owner_ic_q <= gnt_ic;
                if (gnt_ic) begin
                    is_write_q <= 1'b0;
                    addr_q     <= bus.ic_req_addr_i;
                    wr_data_q  <= '0;
                    size_q     <= FULL_LINE_SIZE;
                end else begin
                    is_write_q <= bus.dc_wr_req_i;
                    addr_q     <= bus.dc_req_addr_i;
                    wr_data_q  <= bus.dc_wr_req_i ? bus.dc_wr_data_i : '0;
                    size_q     <= bus.dc_access_size_i;
                end
            end

            if (read_ok) begin
                if (owner_ic_q) begin
                    ic_rsp_data_q <= bus.mem_data_i;
                end else begin
                    dc_rsp_data_q <= bus.mem_data_i;
                end
            end

            if (err_set) begin
                err_q <= 1'b1;
            end

            if (!in_idle && (busy_q != '1)) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign bus.req_is_instr_o    = owner_ic_q;
    assign bus.req_address_o     = addr_q;
    assign bus.wr_data_o         = wr_data_q;
    assign bus.req_access_size_o = size_q;
    assign bus.ic_rsp_data_o     = ic_rsp_data_q;
    assign bus.dc_rsp_data_o     = dc_rsp_data_q;
    assign bus.err_o             = err_q;
    assign bus.busy_cycles_o     = busy_q;
    assign bus.dbg_state         = state_q;

endmodule
